// File: rtl/matrix_anim.sv
// Frame sequencer feeding the 4x4 LED matrix driver: stores up to FRAMES bitmaps, replays them in order.
// Latency: all outputs registered; PLAY is entered (showing frame 0) one clock after play is seen high.
// Backpressure: wr_ready is high only in IDLE; writes stall during playback. Optional macro MATRIX_ANIM_ONESHOT_EN.
//
// Ports: clk/resetn (async active-low); wr_valid/wr_ready/wr_data/wr_last frame load port;
// play level control; hold = clocks per frame; bitmap/frame_idx/wrap/playing playback outputs;
// oneshot (only with MATRIX_ANIM_ONESHOT_EN) stops on the last frame instead of looping.
module matrix_anim #(
    parameter int FRAMES = 8,
    parameter int HOLD_W = 24,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [15:0]       wr_data,
    input  logic              wr_last,
    input  logic              play,
`ifdef MATRIX_ANIM_ONESHOT_EN
    input  logic              oneshot,
`endif
    input  logic [HOLD_W-1:0] hold,
    output logic [15:0]       bitmap,
    output logic [IDX_W-1:0]  frame_idx,
    output logic              wrap,
    output logic              playing
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state_q, state_d;
    logic [15:0]       mem [FRAMES];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W:0]    count;
    logic [HOLD_W-1:0] hold_cnt;

    logic              wr_fire;
    logic              wr_end;
    logic [IDX_W:0]    count_eff;
    logic [HOLD_W-1:0] hold_ld;
    logic              at_last;
    logic              advance;
    logic [IDX_W-1:0]  next_idx;
    logic [15:0]       frame0;
    logic              os_hold;   // last frame reached in oneshot mode: do not wrap
    logic              os_pulse;  // first time os_hold fires: emit the single wrap pulse

    // wr_ready is only ever high while state_q is IDLE, so a transfer implies IDLE.
    assign wr_fire   = wr_valid && wr_ready;
    assign wr_end    = wr_fire && (wr_last || (wr_ptr == IDX_W'(FRAMES - 1)));
    // Count as it will be after this cycle's write, so a closing write and play
    // in the same cycle start the new sequence.
    assign count_eff = wr_end ? ({1'b0, wr_ptr} + (IDX_W+1)'(1)) : count;
    assign hold_ld   = (hold == '0) ? HOLD_W'(1) : hold;
    assign at_last   = ({1'b0, frame_idx} == (count - (IDX_W+1)'(1)));
    assign advance   = (hold_cnt == HOLD_W'(1));
    assign next_idx  = at_last ? '0 : frame_idx + IDX_W'(1);
    // Bypass the storage when frame 0 is being written in the cycle PLAY starts.
    assign frame0    = (wr_fire && (wr_ptr == '0)) ? wr_data : mem[0];

`ifdef MATRIX_ANIM_ONESHOT_EN
    logic os_q;
    logic os_done;

    assign os_hold  = os_q && at_last;
    assign os_pulse = !os_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            os_q    <= 1'b0;
            os_done <= 1'b0;
        end else if (state_q == IDLE && state_d == PLAY) begin
            os_q    <= oneshot;
            os_done <= 1'b0;
        end else if (state_q == PLAY && advance && os_hold) begin
            os_done <= 1'b1;
        end
    end
`else
    assign os_hold  = 1'b0;
    assign os_pulse = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (play && (count_eff != '0)) state_d = PLAY;
            PLAY:    if (!play) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame storage has no reset; contents are meaningless until loaded.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            wr_ready  <= 1'b0;
            playing   <= 1'b0;
            wrap      <= 1'b0;
            bitmap    <= '0;
            frame_idx <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            hold_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ready <= (state_d == IDLE);
            playing  <= (state_d == PLAY);
            wrap     <= 1'b0;
            if (state_q == IDLE) begin
                if (wr_fire) begin
                    if (wr_end) begin
                        count  <= count_eff;
                        wr_ptr <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + IDX_W'(1);
                    end
                end
                if (state_d == PLAY) begin
                    bitmap    <= frame0;
                    frame_idx <= '0;
                    hold_cnt  <= hold_ld;
                    wr_ptr    <= '0;   // discard any partial load
                end
            end else if (state_d == IDLE) begin
                bitmap    <= '0;
                frame_idx <= '0;
            end else if (advance) begin
                hold_cnt <= hold_ld;
                if (os_hold) begin
                    wrap <= os_pulse;
                end else begin
                    frame_idx <= next_idx;
                    bitmap    <= mem[next_idx];
                    wrap      <= at_last;
                end
            end else begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_anim.sv
module tb_matrix_anim;
    localparam int FRAMES = 8;
    localparam int HOLD_W = 24;
    localparam int IDX_W  = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [15:0]       wr_data = '0;
    logic              wr_last = 1'b0;
    logic              play = 1'b0;
    logic [HOLD_W-1:0] hold = '0;
    logic [15:0]       bitmap;
    logic [IDX_W-1:0]  frame_idx;
    logic              wrap;
    logic              playing;
`ifdef MATRIX_ANIM_ONESHOT_EN
    logic              oneshot = 1'b0;
`endif

    matrix_anim #(.FRAMES(FRAMES), .HOLD_W(HOLD_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .play(play),
`ifdef MATRIX_ANIM_ONESHOT_EN
        .oneshot(oneshot),
`endif
        .hold(hold), .bitmap(bitmap), .frame_idx(frame_idx), .wrap(wrap), .playing(playing)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Playback is modelled as "clocks the current frame has been on screen"
    // counted up against the sampled frame length.
    logic [15:0] m_frames [FRAMES];
    int  m_wp = 0, m_count = 0, m_idx = 0, m_el = 0, m_len = 1;
    bit  m_play = 0, m_rdy = 0, m_wrap = 0, m_os = 0, m_done = 0;

    function automatic int frame_len(input logic [HOLD_W-1:0] h);
        return (h == 0) ? 1 : int'(h);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_wp = 0; m_count = 0; m_idx = 0; m_el = 0;
            m_play = 0; m_rdy = 0; m_wrap = 0; m_os = 0; m_done = 0;
        end else begin
            if (wr_valid && m_rdy) begin
                m_frames[m_wp] = wr_data;
                m_wp++;
                if (wr_last || m_wp == FRAMES) begin
                    m_count = m_wp;
                    m_wp = 0;
                end
            end
            m_wrap = 0;
            if (!m_play) begin
                if (play && m_count != 0) begin
                    m_play = 1; m_idx = 0; m_el = 0; m_len = frame_len(hold); m_wp = 0;
                    m_done = 0;
`ifdef MATRIX_ANIM_ONESHOT_EN
                    m_os = oneshot;
`else
                    m_os = 0;
`endif
                end
            end else if (!play) begin
                m_play = 0; m_idx = 0;
            end else begin
                m_el++;
                if (m_el == m_len) begin
                    m_el = 0;
                    m_len = frame_len(hold);
                    if (m_idx == m_count - 1) begin
                        if (m_os) begin
                            m_wrap = !m_done;
                            m_done = 1;
                        end else begin
                            m_wrap = 1;
                            m_idx = 0;
                        end
                    end else begin
                        m_idx++;
                    end
                end
            end
            m_rdy = !m_play;
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        chk("wr_ready",  {31'd0, wr_ready}, {31'd0, m_rdy});
        chk("playing",   {31'd0, playing},  {31'd0, m_play});
        chk("wrap",      {31'd0, wrap},     {31'd0, m_wrap});
        chk("frame_idx", {29'd0, frame_idx}, m_play ? m_idx : 0);
        chk("bitmap",    {16'd0, bitmap},   m_play ? {16'd0, m_frames[m_idx]} : 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic wr(input logic [15:0] d, input logic last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    logic [15:0] t1 [4];
    int wraps;

    initial begin
        t1[0] = 16'h0001; t1[1] = 16'h0010; t1[2] = 16'h8000; t1[3] = 16'h0001;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_bitmap",   {16'd0, bitmap}, 32'd0);
        chk("rst_playing",  {31'd0, playing}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ready_after_rst", {31'd0, wr_ready}, 32'd1);

        // play with nothing loaded is ignored
        play = 1'b1;
        repeat (3) @(negedge clk);
        chk("empty_play_playing", {31'd0, playing}, 32'd0);
        chk("empty_play_bitmap",  {16'd0, bitmap}, 32'd0);
        play = 1'b0;
        @(negedge clk);

        // three frames, hold=4
        hold = 4;
        wr(16'h0001, 1'b0); wr(16'h0010, 1'b0); wr(16'h8000, 1'b1);
        play = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("t1_bitmap", {16'd0, bitmap}, {16'd0, t1[i/4]});
            chk("t1_idx",    {29'd0, frame_idx}, (i/4) % 3);
            chk("t1_wrap",   {31'd0, wrap}, (i == 12) ? 32'd1 : 32'd0);
        end
        play = 1'b0;   // stop mid-frame
        @(negedge clk);
        chk("stop_bitmap", {16'd0, bitmap}, 32'd0);
        chk("stop_ready",  {31'd0, wr_ready}, 32'd1);
        chk("stop_idx",    {29'd0, frame_idx}, 32'd0);

        // two frames, hold=0 -> advance every clock
        hold = 0;
        wr(16'hAAAA, 1'b0); wr(16'h5555, 1'b1);
        play = 1'b1;
        wraps = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_bitmap", {16'd0, bitmap}, (i % 2) ? 32'h5555 : 32'hAAAA);
            if (wrap) wraps++;
        end
        chk("t2_wraps", wraps, 3);
        play = 1'b0;
        @(negedge clk);

        // eight frames, no wr_last: storage fills and closes the sequence
        hold = 1;
        for (int i = 0; i < FRAMES; i++) wr(16'h0001 << (2 * i), 1'b0);
        play = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("t3_bitmap", {16'd0, bitmap}, 32'h0001 << (2 * (i % 8)));
            if (i == 8) chk("t3_wrap", {31'd0, wrap}, 32'd1);
        end
        // write attempted during playback stalls
        wr_valid = 1'b1; wr_data = 16'hBEEF;
        @(negedge clk);
        chk("play_wr_ready", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        play = 1'b0;
        @(negedge clk);
        play = 1'b1;
        @(negedge clk);
        chk("no_store_in_play", {16'd0, bitmap}, 32'h0001);
        play = 1'b0;
        @(negedge clk);

        // partial load: overwrites slots 0,1, count stays 8
        wr(16'hF00F, 1'b0); wr(16'h0FF0, 1'b0);
        play = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("partial_f0", {16'd0, bitmap}, 32'hF00F);
            if (i == 2) chk("partial_f2", {16'd0, bitmap}, 32'h0010);
        end
        play = 1'b0;
        @(negedge clk);

        // closing write and play in the same cycle: single-frame sequence
        hold = 3;
        wr_valid = 1'b1; wr_data = 16'hCAFE; wr_last = 1'b1; play = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; wr_last = 1'b0;
        chk("same_cycle_bitmap",  {16'd0, bitmap}, 32'hCAFE);
        chk("same_cycle_playing", {31'd0, playing}, 32'd1);
        wraps = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (wrap) wraps++;
        end
        chk("count1_wraps", wraps, 3);

        // asynchronous reset mid-playback
        resetn = 1'b0;
        #1;
        chk("async_rst_bitmap",  {16'd0, bitmap}, 32'd0);
        chk("async_rst_playing", {31'd0, playing}, 32'd0);
        play = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

`ifdef MATRIX_ANIM_ONESHOT_EN
        oneshot = 1'b1;
        hold = 2;
        wr(16'h0001, 1'b0); wr(16'h0010, 1'b0); wr(16'h8000, 1'b1);
        play = 1'b1;
        wraps = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wrap) wraps++;
        end
        chk("os_wraps",  wraps, 1);
        chk("os_idx",    {29'd0, frame_idx}, 32'd2);
        chk("os_bitmap", {16'd0, bitmap}, 32'h8000);
        play = 1'b0;
        oneshot = 1'b0;
        repeat (2) @(negedge clk);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
